// File: rtl/instr_queue.sv
// instr_queue: circular FIFO of (pc, instr) pairs between the fetcher and the decoder.
// The head entry is presented combinationally. A flush from the ROB drops all entries.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   is_valid_from_fetcher  push request carrying pc_from_fetcher / instr_from_fetcher
//   is_full_to_fetcher     occupancy == Depth; a push is dropped
//   count_to_fetcher       occupancy, 0..Depth
//   is_pop_from_decoder    consume the head entry
//   is_empty_to_decoder    occupancy == 0; the head outputs read as zero
//   pc_to_decoder          pc of the head entry
//   instr_to_decoder       instruction word of the head entry
//   is_clear_from_rob      flush; discards every entry
module instr_queue #(
   parameter int unsigned QueueAddrWidth = 4,
   parameter int unsigned PcWidth        = 32,
   parameter int unsigned InstrWidth     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      is_valid_from_fetcher,
   input  logic [PcWidth-1:0]        pc_from_fetcher,
   input  logic [InstrWidth-1:0]     instr_from_fetcher,
   output logic                      is_full_to_fetcher,
   input  logic                      is_pop_from_decoder,
   output logic                      is_empty_to_decoder,
   output logic [PcWidth-1:0]        pc_to_decoder,
   output logic [InstrWidth-1:0]     instr_to_decoder,
   input  logic                      is_clear_from_rob,
   output logic [QueueAddrWidth:0]   count_to_fetcher
);

   localparam int unsigned Depth      = 2 ** QueueAddrWidth;
   localparam int unsigned CountWidth = QueueAddrWidth + 1;

   typedef struct packed {
      logic [PcWidth-1:0]    pc;
      logic [InstrWidth-1:0] instr;
   } entry_t;

   entry_t                    entries [Depth];
   logic [QueueAddrWidth-1:0] head;
   logic [QueueAddrWidth-1:0] tail;
   logic [CountWidth-1:0]     count;
   logic                      push_ok;
   logic                      pop_ok;

   // Flags come from the registered count only, so input never bypasses to output.
   assign is_empty_to_decoder = (count == '0);
   assign is_full_to_fetcher  = (count == CountWidth'(Depth));
   assign count_to_fetcher    = count;

   // An empty queue shows zeros rather than a stale entry.
   assign pc_to_decoder    = is_empty_to_decoder ? '0 : entries[head].pc;
   assign instr_to_decoder = is_empty_to_decoder ? '0 : entries[head].instr;

   // Accepted events; a flush or reset cancels both.
   assign push_ok = is_valid_from_fetcher && !is_full_to_fetcher && !is_clear_from_rob && !rst;
   assign pop_ok  = is_pop_from_decoder && !is_empty_to_decoder && !is_clear_from_rob && !rst;

   // Entry storage needs no reset; it is never read while count is zero.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         entries[tail].pc    <= pc_from_fetcher;
         entries[tail].instr <= instr_from_fetcher;
      end
   end

   // Pointer and occupancy update; pointers wrap mod Depth naturally.
   always_ff @(posedge clk) begin
      if (rst || is_clear_from_rob) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            tail <= tail + QueueAddrWidth'(1);
         end
         if (pop_ok) begin
            head <= head + QueueAddrWidth'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CountWidth'(1);
            2'b01:   count <= count - CountWidth'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed test-plan sequences followed by randomized traffic,
// checked against a queue-based reference model of the instruction queue.
module tb_instr_queue;

   logic        clk;
   logic        rst;
   logic        is_valid_from_fetcher;
   logic [31:0] pc_from_fetcher;
   logic [31:0] instr_from_fetcher;
   logic        is_full_to_fetcher;
   logic        is_pop_from_decoder;
   logic        is_empty_to_decoder;
   logic [31:0] pc_to_decoder;
   logic [31:0] instr_to_decoder;
   logic        is_clear_from_rob;
   logic [4:0]  count_to_fetcher;

   instr_queue dut (
      .clk                   (clk),
      .rst                   (rst),
      .is_valid_from_fetcher (is_valid_from_fetcher),
      .pc_from_fetcher       (pc_from_fetcher),
      .instr_from_fetcher    (instr_from_fetcher),
      .is_full_to_fetcher    (is_full_to_fetcher),
      .is_pop_from_decoder   (is_pop_from_decoder),
      .is_empty_to_decoder   (is_empty_to_decoder),
      .pc_to_decoder         (pc_to_decoder),
      .instr_to_decoder      (instr_to_decoder),
      .is_clear_from_rob     (is_clear_from_rob),
      .count_to_fetcher      (count_to_fetcher)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int Depth = 16;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } pair_t;

   pair_t mq[$];
   bit    model_valid = 1'b0;
   int    n_cmp = 0;
   int    n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Compare every DUT output to what the model says the queue holds.
   task automatic compare_outputs(input string when);
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      exp_pc    = (mq.size() > 0) ? mq[0].pc : 32'h0;
      exp_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
      check({when, "_count"}, 64'(count_to_fetcher), 64'(mq.size()));
      check({when, "_empty"}, 64'(is_empty_to_decoder), 64'(mq.size() == 0));
      check({when, "_full"},  64'(is_full_to_fetcher),  64'(mq.size() == Depth));
      check({when, "_pc"},    64'(pc_to_decoder),       64'(exp_pc));
      check({when, "_instr"}, 64'(instr_to_decoder),    64'(exp_instr));
   endtask

   // One clock: drive inputs, check that outputs ignore them before the edge,
   // advance the model across the edge, then check again just after it.
   task automatic step(input bit v, input logic [31:0] p, input logic [31:0] i,
                       input bit pp, input bit cl, input bit r);
      bit push_ok;
      bit pop_ok;
      pair_t e;
      is_valid_from_fetcher = v;
      pc_from_fetcher       = p;
      instr_from_fetcher    = i;
      is_pop_from_decoder   = pp;
      is_clear_from_rob     = cl;
      rst                   = r;
      #1;
      if (model_valid) compare_outputs("pre");
      @(posedge clk);
      push_ok = v && (mq.size() < Depth) && !cl && !r;
      pop_ok  = pp && (mq.size() > 0) && !cl && !r;
      if (r || cl) begin
         mq.delete();
      end else begin
         if (pop_ok) void'(mq.pop_front());
         if (push_ok) begin
            e.pc = p;
            e.instr = i;
            mq.push_back(e);
         end
      end
      if (r) model_valid = 1'b1;
      #1;
      if (model_valid) compare_outputs("post");
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i);
      step(1'b1, p, i, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] tp_instr [3];
      int pv;
      int pp;
      tp_instr[0] = 32'h0000_0013;
      tp_instr[1] = 32'h0010_0093;
      tp_instr[2] = 32'h0020_0113;

      do_reset();
      do_reset();
      check("rst_count", 64'(count_to_fetcher), 64'd0);
      check("rst_empty", 64'(is_empty_to_decoder), 64'd1);
      check("rst_pc",    64'(pc_to_decoder), 64'd0);

      // Three pushes; the first is at the head one cycle later.
      push(32'h0, tp_instr[0]);
      check("tp1_head_pc",    64'(pc_to_decoder), 64'h0);
      check("tp1_head_instr", 64'(instr_to_decoder), 64'h13);
      push(32'h4, tp_instr[1]);
      push(32'h8, tp_instr[2]);
      check("tp1_count", 64'(count_to_fetcher), 64'd3);

      // Drain.
      pop();
      check("tp2_pc1", 64'(pc_to_decoder), 64'h4);
      pop();
      check("tp2_pc2", 64'(pc_to_decoder), 64'h8);
      pop();
      check("tp2_empty", 64'(is_empty_to_decoder), 64'd1);
      check("tp2_instr", 64'(instr_to_decoder), 64'd0);
      pop();  // pop while empty is ignored

      // Fill, overflow, then push+pop while full.
      for (int k = 0; k < 16; k++) push(32'(k * 4), $urandom);
      push(32'h40, $urandom);
      check("tp3_full",  64'(is_full_to_fetcher), 64'd1);
      check("tp3_count", 64'(count_to_fetcher), 64'd16);
      step(1'b1, 32'h44, $urandom, 1'b1, 1'b0, 1'b0);
      check("tp3_count_after", 64'(count_to_fetcher), 64'd15);
      check("tp3_head_pc",     64'(pc_to_decoder), 64'h4);

      // Sustained push+pop at occupancy 5 across pointer wrap.
      do_reset();
      pc = 32'h1000;
      for (int k = 0; k < 5; k++) begin
         push(pc, $urandom);
         pc += 4;
      end
      for (int k = 0; k < 40; k++) begin
         step(1'b1, pc, $urandom, 1'b1, 1'b0, 1'b0);
         pc += 4;
      end
      check("tp4_count", 64'(count_to_fetcher), 64'd5);
      check("tp4_head_pc", 64'(pc_to_decoder), 64'(32'h1000 + 32'd40 * 4));

      // Flush with concurrent push and pop.
      do_reset();
      for (int k = 0; k < 7; k++) push(32'(k * 4), $urandom);
      step(1'b1, 32'h200, $urandom, 1'b1, 1'b1, 1'b0);
      check("tp5_count", 64'(count_to_fetcher), 64'd0);
      check("tp5_empty", 64'(is_empty_to_decoder), 64'd1);
      push(32'h100, 32'hdead_beef);
      check("tp5_pc",    64'(pc_to_decoder), 64'h100);
      check("tp5_count1", 64'(count_to_fetcher), 64'd1);

      // Reset with 9 entries and an active push.
      for (int k = 0; k < 8; k++) push(32'(k * 4 + 32'h300), $urandom);
      check("tp6_count9", 64'(count_to_fetcher), 64'd9);
      step(1'b1, 32'h500, $urandom, 1'b0, 1'b0, 1'b1);
      check("tp6_count", 64'(count_to_fetcher), 64'd0);
      check("tp6_full",  64'(is_full_to_fetcher), 64'd0);
      check("tp6_pc",    64'(pc_to_decoder), 64'd0);

      // Randomized traffic in phases of different push/pop bias.
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin pv = 85; pp = 30; end
            1:       begin pv = 30; pp = 85; end
            default: begin pv = 70; pp = 70; end
         endcase
         for (int k = 0; k < 300; k++) begin
            step(($urandom_range(99) < pv), $urandom, $urandom,
                 ($urandom_range(99) < pp), ($urandom_range(99) < 2),
                 ($urandom_range(299) == 0));
         end
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
